// File: rtl/lx32_arch_pkg.sv
// Shared lx32 architectural types: ALU operations, opcodes, control-sequencer
// states and the control word latched in DECODE.
package lx32_arch_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JAL    = 2'b10;
    localparam logic [1:0] PC_SRC_JALR   = 2'b11;

    localparam logic [1:0] RES_ALU    = 2'b00;
    localparam logic [1:0] RES_LOAD   = 2'b01;
    localparam logic [1:0] RES_PC4    = 2'b10;
    localparam logic [1:0] RES_MULDIV = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_MDWAIT,
        S_WB,
        S_TRAP
    } ctrl_state_e;

    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_MULDIV
    } instr_class_e;

    typedef struct packed {
        instr_class_e cls;
        alu_op_e      alu_op;
        logic [1:0]   alu_src_a;
        logic         alu_src_b;
        logic [2:0]   funct3;
    } ctrl_word_t;

    function automatic logic [1:0] wb_pc_src(input instr_class_e cls);
        case (cls)
            CLS_JAL:  return PC_SRC_JAL;
            CLS_JALR: return PC_SRC_JALR;
            default:  return PC_SRC_PLUS4;
        endcase
    endfunction

    function automatic logic [1:0] wb_result_src(input instr_class_e cls);
        case (cls)
            CLS_LOAD:          return RES_LOAD;
            CLS_JAL, CLS_JALR: return RES_PC4;
            CLS_MULDIV:        return RES_MULDIV;
            default:           return RES_ALU;
        endcase
    endfunction

endpackage

// File: rtl/lx32_alu_decode.sv
// Combinational RV32I ALU operation decode from opcode/funct3/funct7[5].
module lx32_alu_decode
    import lx32_arch_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output alu_op_e    alu_op
);

    logic is_r;
    assign is_r = (opcode == OP_R);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OP_BRANCH) begin
            case (funct3[2:1])
                2'b00:   alu_op = ALU_SUB;
                2'b10:   alu_op = ALU_SLT;
                2'b11:   alu_op = ALU_SLTU;
                default: alu_op = ALU_ADD;
            endcase
        end else if (is_r || opcode == OP_I) begin
            case (funct3)
                3'b000:  alu_op = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/lx32_ctrl_fsm.sv
// Multi-cycle lx32 control sequencer: FETCH/DECODE/EXEC/MEM/MDWAIT/WB/TRAP with
// a latched control word, memory-ready timeout and optional mul/div handshake.
module lx32_ctrl_fsm
    import lx32_arch_pkg::*;
#(
    parameter bit          ENABLE_M  = 1'b1,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    input  logic       md_done,
    output logic       ifetch_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [2:0] branch_cond,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] result_src,
    output alu_op_e    alu_control,
    output logic       mem_req,
    output logic       mem_write,
    output logic       md_start,
    output logic       illegal,
    output logic       bus_err
);

    ctrl_state_e          state;
    ctrl_word_t           ctrl;
    ctrl_word_t           dec_word;
    logic                 dec_illegal;
    alu_op_e              dec_alu_op;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 illegal_q;
    logic                 bus_err_q;
    logic                 is_store;

    lx32_alu_decode u_alu_decode (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_b5 (funct7[5]),
        .alu_op    (dec_alu_op)
    );

    always_comb begin
        dec_word           = '0;
        dec_word.alu_op    = dec_alu_op;
        dec_word.funct3    = funct3;
        dec_word.alu_src_a = SRC_A_RS1;
        dec_word.alu_src_b = 1'b1;
        dec_illegal        = 1'b0;
        case (opcode)
            OP_R: begin
                dec_word.alu_src_b = 1'b0;
                if (funct7 == F7_MULDIV) begin
                    dec_word.cls = CLS_MULDIV;
                    dec_illegal  = !ENABLE_M;
                end else begin
                    dec_word.cls = CLS_ALU_R;
                end
            end
            OP_I:     dec_word.cls = CLS_ALU_I;
            OP_LOAD:  dec_word.cls = CLS_LOAD;
            OP_STORE: dec_word.cls = CLS_STORE;
            OP_BRANCH: begin
                dec_word.cls       = CLS_BRANCH;
                dec_word.alu_src_b = 1'b0;
            end
            OP_JAL:   dec_word.cls = CLS_JAL;
            OP_JALR:  dec_word.cls = CLS_JALR;
            OP_LUI: begin
                dec_word.cls       = CLS_LUI;
                dec_word.alu_src_a = SRC_A_ZERO;
            end
            OP_AUIPC: begin
                dec_word.cls       = CLS_AUIPC;
                dec_word.alu_src_a = SRC_A_PC;
            end
            default:  dec_illegal = 1'b1;
        endcase
    end

    assign is_store = (ctrl.cls == CLS_STORE);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            ctrl      <= '0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (instr_valid) state <= S_DECODE;
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        illegal_q <= 1'b1;
                        state     <= S_TRAP;
                    end else begin
                        ctrl  <= dec_word;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (ctrl.cls)
                        CLS_LOAD, CLS_STORE: begin
                            wait_cnt <= '0;
                            state    <= S_MEM;
                        end
                        CLS_BRANCH: state <= S_FETCH;
                        CLS_MULDIV: state <= S_MDWAIT;
                        default:    state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    // A ready arriving on the all-ones cycle still completes the access.
                    if (mem_ready) begin
                        state <= is_store ? S_FETCH : S_WB;
                    end else if (&wait_cnt) begin
                        bus_err_q <= 1'b1;
                        state     <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + TIMEOUT_W'(1);
                    end
                end
                S_MDWAIT: begin
                    if (md_done) state <= S_WB;
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Strobes decode from state and latched word; reset forces everything low at once.
    always_comb begin
        ifetch_req  = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_PLUS4;
        branch_cond = 3'b000;
        reg_write   = 1'b0;
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = 1'b0;
        result_src  = RES_ALU;
        alu_control = ALU_ADD;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        md_start    = 1'b0;
        illegal     = 1'b0;
        bus_err     = 1'b0;
        if (!rst) begin
            illegal = illegal_q;
            bus_err = bus_err_q;
            if (state == S_EXEC || state == S_MEM || state == S_WB) begin
                alu_control = ctrl.alu_op;
                alu_src_a   = ctrl.alu_src_a;
                alu_src_b   = ctrl.alu_src_b;
            end
            case (state)
                S_FETCH: begin
                    ifetch_req = 1'b1;
                    ir_write   = instr_valid;
                end
                S_EXEC: begin
                    if (ctrl.cls == CLS_BRANCH) begin
                        pc_write    = 1'b1;
                        pc_src      = PC_SRC_BRANCH;
                        branch_cond = ctrl.funct3;
                    end
                    md_start = (ctrl.cls == CLS_MULDIV);
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    mem_write = is_store;
                    pc_write  = is_store && mem_ready;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    pc_src     = wb_pc_src(ctrl.cls);
                    result_src = wb_result_src(ctrl.cls);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lx32_ctrl_fsm.sv
// Self-checking bench for lx32_ctrl_fsm: one instance with mul/div enabled and one
// without, both on a 4-bit timeout, driven by directed and random instructions.
module tb_lx32_ctrl_fsm;
    import lx32_arch_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       mem_ready = 1'b0;
    logic       md_done = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;

    logic m_ifetch_req, m_ir_write, m_pc_write, m_reg_write, m_alu_src_b;
    logic m_mem_req, m_mem_write, m_md_start, m_illegal, m_bus_err;
    logic [1:0] m_pc_src, m_alu_src_a, m_result_src;
    logic [2:0] m_branch_cond;
    alu_op_e    m_alu_control;
    logic n_ifetch_req, n_ir_write, n_pc_write, n_reg_write, n_alu_src_b;
    logic n_mem_req, n_mem_write, n_md_start, n_illegal, n_bus_err;
    logic [1:0] n_pc_src, n_alu_src_a, n_result_src;
    logic [2:0] n_branch_cond;
    alu_op_e    n_alu_control;

    always #5 clk = ~clk;

    lx32_ctrl_fsm #(.ENABLE_M(1'b1), .TIMEOUT_W(4)) dut_m (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .mem_ready(mem_ready), .md_done(md_done),
        .ifetch_req(m_ifetch_req), .ir_write(m_ir_write), .pc_write(m_pc_write), .pc_src(m_pc_src),
        .branch_cond(m_branch_cond), .reg_write(m_reg_write), .alu_src_a(m_alu_src_a),
        .alu_src_b(m_alu_src_b), .result_src(m_result_src), .alu_control(m_alu_control),
        .mem_req(m_mem_req), .mem_write(m_mem_write), .md_start(m_md_start),
        .illegal(m_illegal), .bus_err(m_bus_err)
    );

    lx32_ctrl_fsm #(.ENABLE_M(1'b0), .TIMEOUT_W(4)) dut_n (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .mem_ready(mem_ready), .md_done(md_done),
        .ifetch_req(n_ifetch_req), .ir_write(n_ir_write), .pc_write(n_pc_write), .pc_src(n_pc_src),
        .branch_cond(n_branch_cond), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
        .alu_src_b(n_alu_src_b), .result_src(n_result_src), .alu_control(n_alu_control),
        .mem_req(n_mem_req), .mem_write(n_mem_write), .md_start(n_md_start),
        .illegal(n_illegal), .bus_err(n_bus_err)
    );

    typedef struct packed {
        logic       ifetch_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [2:0] branch_cond;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] result_src;
        logic [3:0] alu_control;
        logic       mem_req;
        logic       mem_write;
        logic       md_start;
        logic       illegal;
        logic       bus_err;
    } outs_t;

    outs_t act_m, act_n;
    assign act_m = {m_ifetch_req, m_ir_write, m_pc_write, m_pc_src, m_branch_cond, m_reg_write,
                    m_alu_src_a, m_alu_src_b, m_result_src, m_alu_control, m_mem_req,
                    m_mem_write, m_md_start, m_illegal, m_bus_err};
    assign act_n = {n_ifetch_req, n_ir_write, n_pc_write, n_pc_src, n_branch_cond, n_reg_write,
                    n_alu_src_a, n_alu_src_b, n_result_src, n_alu_control, n_mem_req,
                    n_mem_write, n_md_start, n_illegal, n_bus_err};

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5;
    localparam int K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_MD = 9, K_BAD = 10;

    int n_cmp = 0;
    int n_bad = 0;
    bit n_trapped = 1'b0;

    function automatic int kind_of(input logic [6:0] op, input logic [6:0] f7);
        case (op)
            7'b0110011: return (f7 == 7'b0000001) ? K_MD : K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            default:    return K_BAD;
        endcase
    endfunction

    // ALU select, operand sources as seen by the datapath for an instruction kind.
    function automatic outs_t alu_fields(input int k, input logic [2:0] f3, input logic [6:0] f7);
        outs_t e = '0;
        alu_op_e op = ALU_ADD;
        if (k == K_BR) begin
            if (f3[2:1] == 2'b00) op = ALU_SUB;
            else if (f3[2:1] == 2'b10) op = ALU_SLT;
            else if (f3[2:1] == 2'b11) op = ALU_SLTU;
        end else if (k == K_R || k == K_I || k == K_MD) begin
            case (f3)
                3'd0: op = (k == K_R && f7[5]) ? ALU_SUB : ALU_ADD;
                3'd1: op = ALU_SLL;
                3'd2: op = ALU_SLT;
                3'd3: op = ALU_SLTU;
                3'd4: op = ALU_XOR;
                3'd5: op = f7[5] ? ALU_SRA : ALU_SRL;
                3'd6: op = ALU_OR;
                default: op = ALU_AND;
            endcase
        end
        e.alu_control = op;
        e.alu_src_a = (k == K_LUI) ? 2'b10 : (k == K_AUIPC) ? 2'b01 : 2'b00;
        e.alu_src_b = !(k == K_R || k == K_BR || k == K_MD);
        return e;
    endfunction

    task automatic step(input string tag, input outs_t exp);
        outs_t exp_n;
        exp_n = exp;
        if (n_trapped) begin
            exp_n = '0;
            exp_n.illegal = 1'b1;
        end
        @(negedge clk);
        n_cmp++;
        assert (act_m === exp) else begin
            n_bad++;
            $error("FAIL %s (M on): observed %h expected %h", tag, act_m, exp);
        end
        n_cmp++;
        assert (act_n === exp_n) else begin
            n_bad++;
            $error("FAIL %s (M off): observed %h expected %h", tag, act_n, exp_n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b1;
        mem_ready = 1'b1;
        md_done = 1'b1;
        n_trapped = 1'b0;
        step("reset_a", '0);
        step("reset_b", '0);
        rst = 1'b0;
    endtask

    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int fwait, input int mwait, input int dwait);
        int k;
        outs_t e, base;
        k = kind_of(op, f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        for (int i = 0; i <= fwait; i++) begin
            instr_valid = (i == fwait);
            mem_ready = 1'($urandom);
            md_done = 1'($urandom);
            e = '0;
            e.ifetch_req = 1'b1;
            e.ir_write = instr_valid;
            step({tag, ".fetch"}, e);
        end
        instr_valid = 1'($urandom);
        step({tag, ".decode"}, '0);
        if (k == K_MD) n_trapped = 1'b1;
        base = alu_fields(k, f3, f7);
        e = base;
        if (k == K_BR) begin
            e.pc_write = 1'b1;
            e.pc_src = 2'b01;
            e.branch_cond = f3;
        end
        e.md_start = (k == K_MD);
        md_done = 1'($urandom);
        mem_ready = 1'($urandom);
        step({tag, ".exec"}, e);
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i <= mwait; i++) begin
                mem_ready = (i == mwait);
                e = base;
                e.mem_req = 1'b1;
                e.mem_write = (k == K_ST);
                e.pc_write = (k == K_ST) && mem_ready;
                step({tag, ".mem"}, e);
            end
        end
        if (k == K_MD) begin
            for (int i = 0; i <= dwait; i++) begin
                md_done = (i == dwait);
                step({tag, ".mdwait"}, '0);
            end
        end
        if (k != K_BR && k != K_ST) begin
            e = base;
            e.reg_write = 1'b1;
            e.pc_write = 1'b1;
            e.pc_src = (k == K_JAL) ? 2'b10 : (k == K_JALR) ? 2'b11 : 2'b00;
            e.result_src = (k == K_LD) ? 2'b01 : (k == K_JAL || k == K_JALR) ? 2'b10 :
                           (k == K_MD) ? 2'b11 : 2'b00;
            step({tag, ".wb"}, e);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t e;
        int sel;
        logic [6:0] rop, rf7;
        logic [2:0] rf3;

        do_reset();

        // ADD x3,x1,x2 with zero-wait handshakes, then shifts and a short load stall.
        run_instr("add", 7'b0110011, 3'b000, 7'b0000000, 0, 0, 0);
        run_instr("sub", 7'b0110011, 3'b000, 7'b0100000, 0, 0, 0);
        run_instr("srai", 7'b0010011, 3'b101, 7'b0100000, 1, 0, 0);
        run_instr("srli", 7'b0010011, 3'b101, 7'b0000000, 0, 0, 0);
        run_instr("addi_f7", 7'b0010011, 3'b000, 7'b0100000, 0, 0, 0);
        run_instr("lw_wait3", 7'b0000011, 3'b010, 7'b0000000, 0, 3, 0);
        run_instr("lw_edge15", 7'b0000011, 3'b010, 7'b0000000, 0, 15, 0);
        run_instr("sw", 7'b0100011, 3'b010, 7'b0000000, 2, 1, 0);
        run_instr("beq", 7'b1100011, 3'b000, 7'b0000000, 0, 0, 0);
        run_instr("bltu", 7'b1100011, 3'b110, 7'b0000000, 0, 0, 0);
        run_instr("jal", 7'b1101111, 3'b000, 7'b0000000, 0, 0, 0);
        run_instr("jalr", 7'b1100111, 3'b000, 7'b0000000, 0, 0, 0);
        run_instr("lui", 7'b0110111, 3'b011, 7'b1010101, 0, 0, 0);
        run_instr("auipc", 7'b0010111, 3'b100, 7'b0001111, 0, 0, 0);
        run_instr("mul", 7'b0110011, 3'b000, 7'b0000001, 0, 0, 5);
        run_instr("after_mul", 7'b0110011, 3'b111, 7'b0000000, 0, 0, 0);

        // Load whose memory never answers: 16 MEM cycles, then a sticky bus error.
        do_reset();
        opcode = 7'b0000011; funct3 = 3'b010; funct7 = '0;
        instr_valid = 1'b1;
        e = '0; e.ifetch_req = 1'b1; e.ir_write = 1'b1;
        step("tmo.fetch", e);
        step("tmo.decode", '0);
        e = alu_fields(K_LD, 3'b010, 7'b0);
        step("tmo.exec", e);
        mem_ready = 1'b0;
        e.mem_req = 1'b1;
        for (int i = 0; i < 16; i++) step("tmo.mem", e);
        mem_ready = 1'b1;
        e = '0; e.bus_err = 1'b1;
        for (int i = 0; i < 3; i++) step("tmo.trap", e);

        // Unknown opcode traps with a sticky illegal flag.
        do_reset();
        opcode = 7'b1111111;
        instr_valid = 1'b1;
        e = '0; e.ifetch_req = 1'b1; e.ir_write = 1'b1;
        step("bad.fetch", e);
        step("bad.decode", '0);
        e = '0; e.illegal = 1'b1;
        for (int i = 0; i < 3; i++) step("bad.trap", e);

        // Reset in the middle of a load access abandons it.
        do_reset();
        opcode = 7'b0000011; funct3 = 3'b000; funct7 = '0;
        instr_valid = 1'b1;
        e = '0; e.ifetch_req = 1'b1; e.ir_write = 1'b1;
        step("rmem.fetch", e);
        step("rmem.decode", '0);
        e = alu_fields(K_LD, 3'b000, 7'b0);
        step("rmem.exec", e);
        mem_ready = 1'b0;
        e.mem_req = 1'b1;
        step("rmem.mem", e);
        rst = 1'b1;
        n_trapped = 1'b0;
        step("rmem.rst", '0);
        rst = 1'b0;
        mem_ready = 1'b1;
        instr_valid = 1'b0;
        e = '0; e.ifetch_req = 1'b1;
        step("rmem.refetch", e);
        run_instr("rmem.next", 7'b0000011, 3'b000, 7'b0000000, 0, 2, 0);

        // Random instruction mix with random handshake delays.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            rf3 = 3'($urandom);
            rf7 = 7'($urandom);
            case (sel)
                0: begin
                    rop = 7'b0110011;
                    rf7 = ((rf3 == 3'd0 || rf3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0;
                end
                1: rop = 7'b0010011;
                2: rop = 7'b0000011;
                3: rop = 7'b0100011;
                4: begin
                    rop = 7'b1100011;
                    if (rf3[2:1] == 2'b01) rf3[2] = 1'b1;
                end
                5: rop = 7'b1101111;
                6: rop = 7'b1100111;
                7: rop = 7'b0110111;
                8: rop = 7'b0010111;
                default: begin
                    rop = 7'b0110011;
                    rf7 = 7'b0000001;
                end
            endcase
            run_instr("rand", rop, rf3, rf7, $urandom_range(0, 3), $urandom_range(0, 15),
                      $urandom_range(0, 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
